vm_purchase_ctrl: RTL and testbench

Purchase sequencer and inventory-port arbiter for the vm2002 vending machine. It accumulates the user's coins and validates each selection against stock and cost. It then commands dispense and change. It is the only writer of the shared inventory write port, so supplier restocks are admitted only when no purchase is in progress.

---
 rtl/vm_purchase_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_vm_purchase_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_purchase_ctrl.sv
// vm_purchase_ctrl: purchase sequencer and sole owner of the inventory write port.
// Latency: balance 1 cycle after coin; dispense 3 cycles after selection, change 1 cycle later.
// Backpressure: restock_ready only in IDLE; coins outside IDLE/COLLECT or on overflow get coin_reject.
//
// Optional feature macro: VM_TIMEOUT_EN
//   Defined: COLLECT auto-refunds after TIMEOUT idle cycles.
//   Undefined: COLLECT waits indefinitely.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   coin_valid/coin_value           coin insert strobe and value (cents)
//   sel_valid/sel_item              product selection strobe
//   cancel                          user cancel strobe
//   restock_valid/_item/_count      supplier restock request; restock_ready accepts it
//   inv_rd_item -> inv_count/cost   combinational inventory lookup
//   inv_wr_en/_inc/_item/_count     registered inventory write (inc = add count, else -1)
//   balance, coin_reject            credit and overflow/illegal-coin pulse
//   dispense_valid/_item            one-cycle dispense command
//   change_valid/_amount            one-cycle change/refund command
//   status                          last event code (held until overwritten)
module vm_purchase_ctrl #(
  parameter int NUM_ITEMS = 8,
  parameter int CNT_W     = 4,
  parameter int BAL_W     = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin_valid,
  input  logic [7:0]                   coin_value,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
  input  logic                         cancel,
  input  logic                         restock_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
  input  logic [CNT_W-1:0]             restock_count,
  output logic                         restock_ready,
  output logic [$clog2(NUM_ITEMS)-1:0] inv_rd_item,
  input  logic [CNT_W-1:0]             inv_count,
  input  logic [BAL_W-1:0]             inv_cost,
  output logic                         inv_wr_en,
  output logic                         inv_wr_inc,
  output logic [$clog2(NUM_ITEMS)-1:0] inv_wr_item,
  output logic [CNT_W-1:0]             inv_wr_count,
  output logic [BAL_W-1:0]             balance,
  output logic                         coin_reject,
  output logic                         dispense_valid,
  output logic [$clog2(NUM_ITEMS)-1:0] dispense_item,
  output logic                         change_valid,
  output logic [BAL_W-1:0]             change_amount,
  output logic [2:0]                   status
);

  localparam int IW = $clog2(NUM_ITEMS);

  localparam logic [2:0] ST_NONE        = 3'd0;
  localparam logic [2:0] ST_VENDED      = 3'd1;
  localparam logic [2:0] ST_NO_STOCK    = 3'd2;
  localparam logic [2:0] ST_LOW_FUNDS   = 3'd3;
  localparam logic [2:0] ST_CANCELLED   = 3'd4;
  localparam logic [2:0] ST_TIMEOUT     = 3'd5;
  localparam logic [2:0] ST_RESTOCK_ERR = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE,
    S_REFUND
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [BAL_W-1:0]  r_balance, w_balance_nxt;
  logic [IW-1:0]     r_sel_item, w_sel_item_nxt;
  logic [BAL_W-1:0]  r_cost, w_cost_nxt;
  logic [2:0]        r_status, w_status_nxt;
  logic              r_coin_reject, w_coin_reject_nxt;
  logic              r_disp_vld, w_disp_vld_nxt;
  logic [IW-1:0]     r_disp_item, w_disp_item_nxt;
  logic              r_chg_vld, w_chg_vld_nxt;
  logic [BAL_W-1:0]  r_chg_amt, w_chg_amt_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic              r_wr_inc, w_wr_inc_nxt;
  logic [IW-1:0]     r_wr_item, w_wr_item_nxt;
  logic [CNT_W-1:0]  r_wr_count, w_wr_count_nxt;

  // One extra bit on both sums so overflow is visible rather than wrapped.
  logic [BAL_W:0]    w_coin_sum;
  logic [CNT_W:0]    w_rs_sum;
  logic              w_rs_fits;
  logic              w_coin_ok_state;
  logic [BAL_W-1:0]  w_remainder;
  logic              w_tmo_hit;

  assign w_coin_sum  = {1'b0, r_balance} + {{(BAL_W-7){1'b0}}, coin_value};
  assign w_rs_sum    = {1'b0, inv_count} + {1'b0, restock_count};
  assign w_rs_fits   = (w_rs_sum <= {1'b0, {CNT_W{1'b1}}});
  assign w_remainder = r_balance - r_cost;

  // The read port serves restock headroom checks in IDLE and the stock/cost
  // lookup of the latched selection everywhere else.
  assign restock_ready = (r_state == S_IDLE);
  assign inv_rd_item   = (r_state == S_IDLE) ? restock_item : r_sel_item;

`ifdef VM_TIMEOUT_EN
  localparam logic [7:0] LP_TMO = TIMEOUT[7:0];
  logic [7:0] r_tmo, w_tmo_nxt;

  assign w_tmo_hit = (r_tmo == LP_TMO);

  // Counts quiet cycles in COLLECT; any user activity restarts it.
  always_comb begin
    w_tmo_nxt = 8'd0;
    if (r_state == S_COLLECT && !cancel && !sel_valid && !coin_valid && !w_tmo_hit)
      w_tmo_nxt = r_tmo + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_tmo <= 8'd0;
    else     r_tmo <= w_tmo_nxt;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_balance_nxt     = r_balance;
    w_sel_item_nxt    = r_sel_item;
    w_cost_nxt        = r_cost;
    w_status_nxt      = r_status;
    w_coin_reject_nxt = 1'b0;
    w_disp_vld_nxt    = 1'b0;
    w_disp_item_nxt   = r_disp_item;
    w_chg_vld_nxt     = 1'b0;
    w_chg_amt_nxt     = r_chg_amt;
    w_wr_en_nxt       = 1'b0;
    w_wr_inc_nxt      = r_wr_inc;
    w_wr_item_nxt     = r_wr_item;
    w_wr_count_nxt    = r_wr_count;
    w_coin_ok_state   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Balance is always zero here, so a selection can never be afforded.
        if (sel_valid)
          w_status_nxt = ST_LOW_FUNDS;
        if (restock_valid) begin
          if (w_rs_fits) begin
            w_wr_en_nxt    = 1'b1;
            w_wr_inc_nxt   = 1'b1;
            w_wr_item_nxt  = restock_item;
            w_wr_count_nxt = restock_count;
          end else begin
            w_status_nxt = ST_RESTOCK_ERR;
          end
        end
        if (coin_valid) begin
          w_coin_ok_state = 1'b1;
          w_state_nxt     = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // A coin arriving alongside cancel or a selection loses priority and
        // is handed back through coin_reject.
        if (cancel) begin
          w_status_nxt = ST_CANCELLED;
          w_state_nxt  = S_REFUND;
        end else if (sel_valid) begin
          w_sel_item_nxt = sel_item;
          w_state_nxt    = S_CHECK;
        end else if (coin_valid) begin
          w_coin_ok_state = 1'b1;
        end else if (w_tmo_hit) begin
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = S_REFUND;
        end
      end

      S_CHECK: begin
        if (inv_count == '0) begin
          w_status_nxt = ST_NO_STOCK;
          w_state_nxt  = S_COLLECT;
        end else if (r_balance < inv_cost) begin
          w_status_nxt = ST_LOW_FUNDS;
          w_state_nxt  = S_COLLECT;
        end else begin
          // Cost is captured so DISPENSE does not depend on the read port.
          w_cost_nxt  = inv_cost;
          w_state_nxt = S_DISPENSE;
        end
      end

      S_DISPENSE: begin
        w_disp_vld_nxt  = 1'b1;
        w_disp_item_nxt = r_sel_item;
        w_wr_en_nxt     = 1'b1;
        w_wr_inc_nxt    = 1'b0;
        w_wr_item_nxt   = r_sel_item;
        w_wr_count_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
        w_balance_nxt   = w_remainder;
        w_status_nxt    = ST_VENDED;
        w_state_nxt     = (w_remainder != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE, S_REFUND: begin
        w_chg_vld_nxt = 1'b1;
        w_chg_amt_nxt = r_balance;
        w_balance_nxt = '0;
        w_state_nxt   = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (coin_valid) begin
      if (w_coin_ok_state && !w_coin_sum[BAL_W])
        w_balance_nxt = w_coin_sum[BAL_W-1:0];
      else
        w_coin_reject_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_balance     <= '0;
      r_sel_item    <= '0;
      r_cost        <= '0;
      r_status      <= ST_NONE;
      r_coin_reject <= 1'b0;
      r_disp_vld    <= 1'b0;
      r_disp_item   <= '0;
      r_chg_vld     <= 1'b0;
      r_chg_amt     <= '0;
      r_wr_en       <= 1'b0;
      r_wr_inc      <= 1'b0;
      r_wr_item     <= '0;
      r_wr_count    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_balance     <= w_balance_nxt;
      r_sel_item    <= w_sel_item_nxt;
      r_cost        <= w_cost_nxt;
      r_status      <= w_status_nxt;
      r_coin_reject <= w_coin_reject_nxt;
      r_disp_vld    <= w_disp_vld_nxt;
      r_disp_item   <= w_disp_item_nxt;
      r_chg_vld     <= w_chg_vld_nxt;
      r_chg_amt     <= w_chg_amt_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_inc      <= w_wr_inc_nxt;
      r_wr_item     <= w_wr_item_nxt;
      r_wr_count    <= w_wr_count_nxt;
    end
  end

  assign balance        = r_balance;
  assign coin_reject    = r_coin_reject;
  assign dispense_valid = r_disp_vld;
  assign dispense_item  = r_disp_item;
  assign change_valid   = r_chg_vld;
  assign change_amount  = r_chg_amt;
  assign inv_wr_en      = r_wr_en;
  assign inv_wr_inc     = r_wr_inc;
  assign inv_wr_item    = r_wr_item;
  assign inv_wr_count   = r_wr_count;
  assign status         = r_status;

endmodule

// File: tb/tb_vm_purchase_ctrl.sv
// tb_vm_purchase_ctrl: directed checks of vend, refusal, cancel, restock,
// overflow, reset and timeout behaviour of vm_purchase_ctrl.
// Drives on posedge+1, samples on posedge+1 (registered outputs settled).
module tb_vm_purchase_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_valid;
  logic [7:0]  coin_value;
  logic        sel_valid;
  logic [2:0]  sel_item;
  logic        cancel;
  logic        restock_valid;
  logic [2:0]  restock_item;
  logic [3:0]  restock_count;
  logic        restock_ready;
  logic [2:0]  inv_rd_item;
  logic [3:0]  inv_count;
  logic [15:0] inv_cost;
  logic        inv_wr_en;
  logic        inv_wr_inc;
  logic [2:0]  inv_wr_item;
  logic [3:0]  inv_wr_count;
  logic [15:0] balance;
  logic        coin_reject;
  logic        dispense_valid;
  logic [2:0]  dispense_item;
  logic        change_valid;
  logic [15:0] change_amount;
  logic [2:0]  status;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vm_purchase_ctrl dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .restock_valid(restock_valid), .restock_item(restock_item),
    .restock_count(restock_count), .restock_ready(restock_ready),
    .inv_rd_item(inv_rd_item), .inv_count(inv_count), .inv_cost(inv_cost),
    .inv_wr_en(inv_wr_en), .inv_wr_inc(inv_wr_inc),
    .inv_wr_item(inv_wr_item), .inv_wr_count(inv_wr_count),
    .balance(balance), .coin_reject(coin_reject),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amount(change_amount),
    .status(status)
  );

  // Inventory store: loaded on reset, updated by the DUT write port.
  logic [3:0]  stock [8];
  logic [15:0] cost  [8];

  assign inv_count = stock[inv_rd_item];
  assign inv_cost  = cost[inv_rd_item];

  always @(posedge clk) begin
    if (rst) begin
      stock[0] <= 4'd0;  cost[0] <= 16'd50;
      stock[1] <= 4'd4;  cost[1] <= 16'd20;
      stock[2] <= 4'd3;  cost[2] <= 16'd100;
      stock[3] <= 4'd5;  cost[3] <= 16'd75;
      stock[4] <= 4'd1;  cost[4] <= 16'd30;
      stock[5] <= 4'd10; cost[5] <= 16'd10;
      stock[6] <= 4'd12; cost[6] <= 16'd40;
      stock[7] <= 4'd15; cost[7] <= 16'd60;
    end else if (inv_wr_en) begin
      if (inv_wr_inc) stock[inv_wr_item] <= stock[inv_wr_item] + inv_wr_count;
      else            stock[inv_wr_item] <= stock[inv_wr_item] - 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 0; coin_value = 0; sel_valid = 0; sel_item = 0;
    cancel = 0; restock_valid = 0; restock_item = 0; restock_count = 0;
  endtask

  task automatic put_coin(input logic [7:0] v);
    coin_valid = 1; coin_value = v;
    step();
    coin_valid = 0; coin_value = 0;
  endtask

  initial begin
    int seen;
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;

    // Reset state
    check("rst_balance", balance, 0);
    check("rst_status", status, 0);
    check("rst_disp", dispense_valid, 0);
    check("rst_chg", change_valid, 0);
    check("rst_wr_en", inv_wr_en, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_rdy", restock_ready, 1);

    // Selection with zero balance in IDLE
    sel_valid = 1; sel_item = 2;
    step();
    sel_valid = 0;
    check("idle_sel_status", status, 3);
    check("idle_sel_rdy", restock_ready, 1);

    // Vend with change: 100 + 25, item 2 costs 100
    put_coin(8'd100);
    check("bal_100", balance, 100);
    put_coin(8'd25);
    check("bal_125", balance, 125);
    sel_valid = 1; sel_item = 2;
    step();
    sel_valid = 0;
    check("no_disp_early", dispense_valid, 0);
    step();
    check("no_disp_early2", dispense_valid, 0);
    step();
    check("disp_vld", dispense_valid, 1);
    check("disp_item", dispense_item, 2);
    check("dec_wr_en", inv_wr_en, 1);
    check("dec_wr_inc", inv_wr_inc, 0);
    check("dec_wr_item", inv_wr_item, 2);
    check("vend_bal", balance, 25);
    check("vend_status", status, 1);
    step();
    check("disp_pulse", dispense_valid, 0);
    check("chg_vld", change_valid, 1);
    check("chg_amt", change_amount, 25);
    check("chg_bal", balance, 0);
    check("stock2_after", stock[2], 2);
    step();
    check("chg_pulse", change_valid, 0);

    // No stock, then low funds
    put_coin(8'd50);
    sel_valid = 1; sel_item = 0;
    step(); sel_valid = 0;
    step();
    check("nostock_status", status, 2);
    check("nostock_bal", balance, 50);
    sel_valid = 1; sel_item = 3;
    step(); sel_valid = 0;
    step();
    check("lowfunds_status", status, 3);
    check("lowfunds_bal", balance, 50);
    check("collect_not_rdy", restock_ready, 0);
    step();
    check("lowfunds_no_disp", dispense_valid, 0);

    // Cancel with 60 credited
    put_coin(8'd10);
    check("bal_60", balance, 60);
    cancel = 1;
    step(); cancel = 0;
    check("cancel_status", status, 4);
    check("cancel_no_wr", inv_wr_en, 0);
    step();
    check("refund_vld", change_valid, 1);
    check("refund_amt", change_amount, 60);
    check("refund_no_wr", inv_wr_en, 0);
    check("refund_bal", balance, 0);
    step();

    // Restock: item 5 stock 10 + 5 fits exactly
    restock_valid = 1; restock_item = 5; restock_count = 5;
    #1;
    check("rs_rdy", restock_ready, 1);
    check("rs_rd_item", inv_rd_item, 5);
    step();
    restock_valid = 0;
    check("rs_wr_en", inv_wr_en, 1);
    check("rs_wr_inc", inv_wr_inc, 1);
    check("rs_wr_item", inv_wr_item, 5);
    check("rs_wr_count", inv_wr_count, 5);
    step();
    check("stock5_15", stock[5], 15);
    // Item 6 stock 12 + 5 overflows
    restock_valid = 1; restock_item = 6; restock_count = 5;
    step();
    restock_valid = 0;
    check("rs_err_no_wr", inv_wr_en, 0);
    check("rs_err_status", status, 6);

    // Coin and restock together in IDLE
    coin_valid = 1; coin_value = 5;
    restock_valid = 1; restock_item = 1; restock_count = 2;
    step();
    idle_inputs();
    check("both_wr_en", inv_wr_en, 1);
    check("both_wr_item", inv_wr_item, 1);
    check("both_wr_count", inv_wr_count, 2);
    check("both_bal", balance, 5);
    check("both_not_rdy", restock_ready, 0);
    cancel = 1; step(); cancel = 0;
    step();
    check("both_refund", change_amount, 5);
    step();

    // Balance overflow: build 0xFFF0 = 256*255 + 240
    for (int i = 0; i < 256; i++) put_coin(8'd255);
    put_coin(8'd240);
    check("bal_fff0", balance, 16'hFFF0);
    put_coin(8'h20);
    check("ovf_reject", coin_reject, 1);
    check("ovf_bal", balance, 16'hFFF0);
    step();
    check("reject_pulse", coin_reject, 0);
    put_coin(8'h0F);
    check("bal_ffff", balance, 16'hFFFF);
    check("ffff_no_reject", coin_reject, 0);
    cancel = 1; step(); cancel = 0;
    // Coin in REFUND is rejected
    put_coin(8'd1);
    check("refund_coin_reject", coin_reject, 1);
    check("big_refund", change_amount, 16'hFFFF);
    step();

    // Reset mid-purchase
    put_coin(8'd40);
    sel_valid = 1; sel_item = 5;
    step(); sel_valid = 0;
    rst = 1;
    step();
    rst = 0;
    check("midrst_bal", balance, 0);
    check("midrst_disp", dispense_valid, 0);
    check("midrst_wr", inv_wr_en, 0);
    check("midrst_rdy", restock_ready, 1);
    step();
    check("midrst_chg", change_valid, 0);
    check("midrst_wr2", inv_wr_en, 0);

    // Timeout
    put_coin(8'd10);
    seen = 0;
`ifdef VM_TIMEOUT_EN
    for (int i = 0; i < 400 && seen == 0; i++) begin
      step();
      if (change_valid) begin
        seen = 1;
        check("tmo_amt", change_amount, 10);
        check("tmo_status", status, 5);
      end
    end
    check("tmo_seen", seen, 1);
`else
    for (int i = 0; i < 300; i++) begin
      step();
      if (change_valid) seen++;
    end
    check("no_tmo_refund", seen, 0);
    check("no_tmo_bal", balance, 10);
    cancel = 1; step(); cancel = 0;
    step();
    check("late_cancel_amt", change_amount, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
